entropy_seed_collector: RTL
===========================

// Module: entropy_seed_collector
// PURPOSE
//  Consumer side of ring_oscillator: turns one raw oscillator bit into SEED_WIDTH-bit seeds for downstream PRNGs.
//  Decimates raw samples, removes bias with a von Neumann corrector and runs a repetition-count health test.
//  Hands each finished seed out over a valid/ready handshake.
//  Sits between ring_oscillator (out[k]) and the PRNG seed-load port.
// PARAMETERS
//  SEED_WIDTH  32  bits per seed delivered; >=2
//  SAMPLE_DIV  4   raw_bit sampled once every SAMPLE_DIV clocks while collecting; >=1
//  REP_LIMIT   16  consecutive identical samples that trip health_fail; >=2
// PORTS
//  clk          in   1           system clock
//  rst_n        in   1           reset, synchronous, active-low
//  raw_bit      in   1           oscillator bit, already registered in clk domain
//  start        in   1           request one seed; honoured only in IDLE
//  seed         out  SEED_WIDTH  collected seed; stable while seed_valid
//  seed_valid   out  1           seed available
//  seed_ready   in   1           consumer accepts seed when seed_valid&&seed_ready
//  busy         out  1           high in COLLECT
//  health_fail  out  1           sticky entropy-source failure
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; seed, seed_valid, busy, health_fail, all counters, pair flag = 0.
//  FSM states: IDLE, COLLECT, HOLD, FAIL.
//  - IDLE: start=1 -> COLLECT next cycle. Clears seed, bit count, divider, pair flag and run counter.
//  - COLLECT: divider counts 0..SAMPLE_DIV-1. Sample strobe when divider==SAMPLE_DIV-1 (every cycle if SAMPLE_DIV=1).
//    The first strobe comes SAMPLE_DIV cycles after entry.
//  - Von Neumann: odd strobe stores sample s0 and sets the pair flag; even strobe takes s1 and clears the flag.
//    If s0!=s1: shift s0 into seed, seed <= {seed[SEED_WIDTH-2:0], s0}, bit count+1.
//    If s0==s1: discard, no shift.
//    Pairing is strictly on strobe order; there is no overlap between pairs.
//  - Run counter: counts the current run length of identical samples over every strobe, across pair boundaries.
//    The first strobe after start sets run=1. A differing sample sets run=1; an equal sample sets run=run+1.
//    When run reaches REP_LIMIT: state -> FAIL.
//  - Bit count reaching SEED_WIDTH -> HOLD next cycle, with seed_valid=1 in HOLD.
//  - Same strobe completes seed and trips health test: FAIL wins, seed_valid stays 0.
//  - HOLD: seed and seed_valid held until seed_valid&&seed_ready. The cycle after acceptance: IDLE, seed_valid=0.
//    seed keeps its value until the next start.
//  - FAIL: health_fail=1, busy=0, seed_valid=0. start ignored; only rst_n leaves FAIL.
//  - start outside IDLE: ignored, with no queueing.
//  - raw_bit is ignored except at strobes.
//  - busy = (state==COLLECT), registered with the state.
//  - Minimum latency from the start cycle to seed_valid = 2*SEED_WIDTH*SAMPLE_DIV + 1 cycles.
//    Each discarded pair adds 2*SAMPLE_DIV cycles.
//  - Counter widths: $clog2(SEED_WIDTH+1), $clog2(SAMPLE_DIV), $clog2(REP_LIMIT+1). No wrap-around is reachable.
// TESTING
//  1. SEED_WIDTH=8, SAMPLE_DIV=1, REP_LIMIT=16; start at cycle 0; raw_bit pairs 10,01 repeated.
//     -> seed_valid rises at cycle 17, seed=8'hAA, busy high cycles 1..16.
//  2. As 1 with pairs 00 and 11 inserted after the 2nd pair.
//     -> same seed=8'hAA, seed_valid at cycle 21, run counter never reaches 16.
//  3. raw_bit held at 1, start at cycle 0, SAMPLE_DIV=1.
//     -> health_fail=1 and state FAIL at cycle 17 (16th strobe), seed_valid never asserts.
//     -> Later start pulses ignored until rst_n.
//  4. HOLD with seed_ready=0 for 10 cycles plus start pulses.
//     -> seed/seed_valid unchanged, start ignored.
//     -> seed_ready=1: handshake, seed_valid=0 next cycle; a new start then begins COLLECT.
//  5. rst_n=0 for one cycle mid-COLLECT.
//     -> next cycle all outputs 0, state IDLE.
//     -> New start with pattern of test 1 yields 8'hAA with the test-1 latency.
//  6. SAMPLE_DIV=4, raw_bit flipped on non-strobe cycles only.
//     -> seed determined solely by strobe-cycle values; seed_valid at start+65 cycles.

Source files
------------

// File: rtl/entropy_seed_collector.sv
// Entropy seed collector: decimates a raw oscillator bit, removes bias with a
// von Neumann corrector, watches for stuck sources with a repetition-count
// health test, and hands finished seeds out over a valid/ready handshake.
module entropy_seed_collector #(
  parameter int SEED_WIDTH = 32,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  raw_bit,
  input  logic                  start,
  output logic [SEED_WIDTH-1:0] seed,
  output logic                  seed_valid,
  input  logic                  seed_ready,
  output logic                  busy,
  output logic                  health_fail
);

  // A divide-by-one divider still needs a one-bit register to stay legal.
  localparam int CNT_W = $clog2(SEED_WIDTH + 1);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] SEED_FULL = CNT_W'(SEED_WIDTH);
  localparam logic [RUN_W-1:0] RUN_TRIP  = RUN_W'(REP_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    FAIL    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;
  logic             pair_flag;
  logic             first_sample;
  logic             last_sample;

  logic             strobe;
  logic             keep_bit;
  logic             seed_done;
  logic             health_trip;
  logic             launch;

  // The sample strobe fires on the last divider count while collecting.
  assign strobe = (state == COLLECT) && (div_cnt == DIV_LAST);
  assign launch = (state == IDLE) && start;

  // Health test and von Neumann decisions for the current strobe.
  always_comb begin
    run_nxt     = run_cnt;
    keep_bit    = 1'b0;
    bit_cnt_nxt = bit_cnt;
    if (strobe) begin
      if ((run_cnt == '0) || (raw_bit != last_sample)) begin
        run_nxt = RUN_W'(1);
      end else begin
        run_nxt = run_cnt + RUN_W'(1);
      end
      if (pair_flag && (first_sample != raw_bit)) begin
        keep_bit    = 1'b1;
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
      end
    end
    health_trip = strobe && (run_nxt == RUN_TRIP);
    seed_done   = keep_bit && (bit_cnt_nxt == SEED_FULL);
  end

  // State register; everything visible outside is decoded from it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; a health trip outranks a completed seed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (health_trip) begin
          state_nxt = FAIL;
        end else if (seed_done) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (seed_ready) begin
          state_nxt = IDLE;
        end
      end
      FAIL: begin
        state_nxt = FAIL;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: cleared on an accepted start, advanced only while collecting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed         <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      run_cnt      <= '0;
      pair_flag    <= 1'b0;
      first_sample <= 1'b0;
      last_sample  <= 1'b0;
    end else if (launch) begin
      seed         <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      run_cnt      <= '0;
      pair_flag    <= 1'b0;
      first_sample <= 1'b0;
      last_sample  <= 1'b0;
    end else if (state == COLLECT) begin
      if (strobe) begin
        div_cnt     <= '0;
        run_cnt     <= run_nxt;
        last_sample <= raw_bit;
        if (!pair_flag) begin
          first_sample <= raw_bit;
          pair_flag    <= 1'b1;
        end else begin
          pair_flag <= 1'b0;
          if (keep_bit) begin
            seed    <= {seed[SEED_WIDTH-2:0], first_sample};
            bit_cnt <= bit_cnt_nxt;
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign busy        = (state == COLLECT);
  assign seed_valid  = (state == HOLD);
  assign health_fail = (state == FAIL);

endmodule
